// File: rtl/bus_pkg.sv
// Shared bus constants: beat width and the fixed test sequence
// that both master and slave agree on.
package bus_pkg;
    localparam int DATA_W  = 3;
    localparam int SEQ_LEN = 3;

    typedef logic [DATA_W-1:0] data_t;

    localparam data_t SEQ0 = 3'b111;
    localparam data_t SEQ1 = 3'b101;
    localparam data_t SEQ2 = 3'b110;

    function automatic data_t seq_exp(input logic [1:0] idx);
        data_t v;
        case (idx)
            2'd1:    v = SEQ1;
            2'd2:    v = SEQ2;
            default: v = SEQ0;
        endcase
        return v;
    endfunction
endpackage

// File: rtl/slave_sync_fifo.sv
// Small synchronous FIFO; head is zero when empty, no pass-through.
module sync_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] din,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; the empty flag masks stale entries.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: rtl/slave.sv
// Handshake receiver: throttled ready, FIFO buffering, beat counter
// and a sticky checker against the fixed master sequence.
module slave
    import bus_pkg::*;
#(
    parameter int         DEPTH         = 4,
    parameter logic [3:0] READY_PATTERN = 4'b1111
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              valid_up,
    input  logic [DATA_W-1:0] data_up,
    output logic              ready_up,
    output logic              valid_dn,
    output logic [DATA_W-1:0] data_dn,
    input  logic              ready_dn,
    output logic [7:0]        beat_cnt,
    output logic              seq_err
);
    logic [1:0] phase_q, phase_d;
    logic [1:0] exp_idx_q, exp_idx_d;
    logic [7:0] beat_cnt_q, beat_cnt_d;
    logic       seq_err_q, seq_err_d;
    logic       full, empty, push, pop;

    // Ready is a function of registered state only.
    assign ready_up = !full && READY_PATTERN[phase_q];
    assign push     = valid_up && ready_up;
    assign pop      = valid_dn && ready_dn;
    assign valid_dn = !empty;
    assign beat_cnt = beat_cnt_q;
    assign seq_err  = seq_err_q;

    sync_fifo #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk  (sys_clk),
        .rst  (sys_rst),
        .push (push),
        .pop  (pop),
        .din  (data_up),
        .full (full),
        .empty(empty),
        .dout (data_dn)
    );

    always_comb begin
        phase_d    = phase_q + 2'd1;
        exp_idx_d  = exp_idx_q;
        beat_cnt_d = beat_cnt_q;
        seq_err_d  = seq_err_q;
        if (!valid_up) begin
            exp_idx_d = 2'd0;
        end else if (push) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
            if (data_up != seq_exp(exp_idx_q)) seq_err_d = 1'b1;
            if (exp_idx_q == 2'(SEQ_LEN - 1)) exp_idx_d = 2'd0;
            else exp_idx_d = exp_idx_q + 2'd1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            phase_q    <= 2'd0;
            exp_idx_q  <= 2'd0;
            beat_cnt_q <= 8'd0;
            seq_err_q  <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            exp_idx_q  <= exp_idx_d;
            beat_cnt_q <= beat_cnt_d;
            seq_err_q  <= seq_err_d;
        end
    end
endmodule

// File: tb/tb_slave.sv
// Directed bench for slave: default pattern instance plus a
// 4'b0101-throttled instance sharing clock and reset.
module tb_slave;
    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       valid_up = 1'b0, ready_dn = 1'b0;
    logic [2:0] data_up = 3'd0;
    logic       ready_up, valid_dn, seq_err;
    logic [2:0] data_dn;
    logic [7:0] beat_cnt;
    logic       valid_up2 = 1'b0, ready_dn2 = 1'b0;
    logic [2:0] data_up2 = 3'd0;
    logic       ready_up2, valid_dn2, seq_err2;
    logic [2:0] data_dn2;
    logic [7:0] beat_cnt2;
    int n_vec = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;

    slave #(.DEPTH(4), .READY_PATTERN(4'b1111)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .valid_up(valid_up), .data_up(data_up), .ready_up(ready_up),
        .valid_dn(valid_dn), .data_dn(data_dn), .ready_dn(ready_dn),
        .beat_cnt(beat_cnt), .seq_err(seq_err)
    );

    slave #(.DEPTH(4), .READY_PATTERN(4'b0101)) dut2 (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .valid_up(valid_up2), .data_up(data_up2), .ready_up(ready_up2),
        .valid_dn(valid_dn2), .data_dn(data_dn2), .ready_dn(ready_dn2),
        .beat_cnt(beat_cnt2), .seq_err(seq_err2)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic st(input string tag, input logic v, input logic [2:0] d,
                      input logic [7:0] bc, input logic e);
        chk({tag, ".valid_dn"}, {7'd0, valid_dn}, {7'd0, v});
        chk({tag, ".data_dn"}, {5'd0, data_dn}, {5'd0, d});
        chk({tag, ".beat_cnt"}, beat_cnt, bc);
        chk({tag, ".seq_err"}, {7'd0, seq_err}, {7'd0, e});
    endtask

    initial begin
        tick();
        st("rst", 1'b0, 3'd0, 8'd0, 1'b0);
        chk("rst.ready_up", {7'd0, ready_up}, 8'd1);
        chk("rst.ready_up2", {7'd0, ready_up2}, 8'd1);
        sys_rst = 1'b0;

        // Basic stream with downstream always ready
        ready_dn = 1'b1; valid_up = 1'b1;
        data_up = 3'b111; tick(); st("t1a", 1'b1, 3'b111, 8'd1, 1'b0);
        data_up = 3'b101; tick(); st("t1b", 1'b1, 3'b101, 8'd2, 1'b0);
        data_up = 3'b110; tick(); st("t1c", 1'b1, 3'b110, 8'd3, 1'b0);
        valid_up = 1'b0; tick(); st("t1d", 1'b0, 3'd0, 8'd3, 1'b0);

        // Fill to full with downstream stalled
        ready_dn = 1'b0; valid_up = 1'b1;
        data_up = 3'b111; tick();
        data_up = 3'b101; tick();
        data_up = 3'b110; tick();
        chk("t2.ready3", {7'd0, ready_up}, 8'd1);
        data_up = 3'b111; tick();
        chk("t2.ready4", {7'd0, ready_up}, 8'd0);
        st("t2.full", 1'b1, 3'b111, 8'd7, 1'b0);
        data_up = 3'b101; tick();
        chk("t2.hold", beat_cnt, 8'd7);
        chk("t2.hold_rdy", {7'd0, ready_up}, 8'd0);
        valid_up = 1'b0; ready_dn = 1'b1; tick();
        chk("t2.rise", {7'd0, ready_up}, 8'd1);
        st("t2.p1", 1'b1, 3'b101, 8'd7, 1'b0);
        tick(); st("t2.p2", 1'b1, 3'b110, 8'd7, 1'b0);
        tick(); st("t2.p3", 1'b1, 3'b111, 8'd7, 1'b0);
        tick(); st("t2.p4", 1'b0, 3'd0, 8'd7, 1'b0);

        // Valid drop restarts the expected sequence
        valid_up = 1'b1;
        data_up = 3'b111; tick();
        data_up = 3'b101; tick();
        valid_up = 1'b0; tick();
        valid_up = 1'b1;
        data_up = 3'b111; tick(); st("t5a", 1'b1, 3'b111, 8'd10, 1'b0);
        data_up = 3'b101; tick(); st("t5b", 1'b1, 3'b101, 8'd11, 1'b0);
        valid_up = 1'b0; tick();

        // Corrupted second beat sets a sticky error
        valid_up = 1'b1;
        data_up = 3'b111; tick(); st("t4a", 1'b1, 3'b111, 8'd12, 1'b0);
        data_up = 3'b000; tick(); st("t4b", 1'b1, 3'b000, 8'd13, 1'b1);
        data_up = 3'b110; tick(); st("t4c", 1'b1, 3'b110, 8'd14, 1'b1);
        valid_up = 1'b0; tick(); st("t4d", 1'b0, 3'd0, 8'd14, 1'b1);

        // Async reset with three beats buffered
        ready_dn = 1'b0; valid_up = 1'b1;
        data_up = 3'b111; tick();
        data_up = 3'b101; tick();
        data_up = 3'b110; tick();
        st("t6.pre", 1'b1, 3'b111, 8'd17, 1'b1);
        valid_up = 1'b0;
        sys_rst = 1'b1; #1;
        st("t6.rst", 1'b0, 3'd0, 8'd0, 1'b0);
        #2 sys_rst = 1'b0;
        chk("t6.ready", {7'd0, ready_up}, 8'd1);
        chk("t6.ready2", {7'd0, ready_up2}, 8'd1);
        tick(); st("t6.post", 1'b0, 3'd0, 8'd0, 1'b0);

        // Throttled instance: ready only in phases 0 and 2
        sys_rst = 1'b1; #1 sys_rst = 1'b0;
        ready_dn2 = 1'b1; valid_up2 = 1'b1; data_up2 = 3'b111;
        tick();
        chk("t3.d1", {5'd0, data_dn2}, 8'h7);
        chk("t3.r1", {7'd0, ready_up2}, 8'd0);
        data_up2 = 3'b101; tick();
        chk("t3.r2", {7'd0, ready_up2}, 8'd1);
        chk("t3.v2", {7'd0, valid_dn2}, 8'd0);
        chk("t3.c2", beat_cnt2, 8'd1);
        tick();
        chk("t3.d3", {5'd0, data_dn2}, 8'h5);
        chk("t3.r3", {7'd0, ready_up2}, 8'd0);
        data_up2 = 3'b110; tick();
        chk("t3.r4", {7'd0, ready_up2}, 8'd1);
        tick();
        chk("t3.d5", {5'd0, data_dn2}, 8'h6);
        chk("t3.c5", beat_cnt2, 8'd3);
        chk("t3.e5", {7'd0, seq_err2}, 8'd0);
        valid_up2 = 1'b0; tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/slave.md
# slave

Receiving end of the valid/ready bus handshake driven by `master`: accepts only beats where `valid_up` and `ready_up` are both high and buffers them in a small FIFO. Exposes them to a downstream consumer through a second valid/ready port. Applies a programmable ready-throttle pattern to exercise upstream stalls. Checks the accepted stream against the fixed test sequence 3'b111, 3'b101, 3'b110, flagging mismatches and counting accepted beats.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `READY_PATTERN`, 4'b1111: per-phase ready enable; bit `phase` gates `ready_up`.

- `sys_clk`  in  1  clock, all state on rising edge.
- `sys_rst`  in  1  reset, asynchronous, active-high.
- `valid_up`  in  1  upstream beat valid.
- `data_up`  in  3  upstream beat data.
- `ready_up`  out  1  upstream ready.
- `valid_dn`  out  1  buffered beat available.
- `data_dn`  out  3  buffered beat data (FIFO head).
- `ready_dn`  in  1  downstream consumer ready.
- `beat_cnt`  out  8  accepted-beat count.
- `seq_err`  out  1  sticky sequence-mismatch flag.

## Operation
- `phase`: 2-bit free-running counter. Reset 0. Increments every cycle and wraps 3→0.
- `ready_up` = !full && READY_PATTERN[phase]. Depends only on registered state, never on `valid_up` or `ready_dn`.
- push = valid_up && ready_up. pop = valid_dn && ready_dn.
- Push and pop in the same cycle: both occur and occupancy is unchanged.
- When full, push is impossible even if pop occurs that cycle; there is no same-cycle pass-through.
- FIFO: pointers of log2(DEPTH) bits wrap naturally. Occupancy count has log2(DEPTH)+1 bits. full = (count==DEPTH), empty = (count==0).
- `valid_dn` = !empty. `data_dn` = mem[rd_ptr] when !empty, 3'd0 when empty.
- `beat_cnt`: +1 per push, wraps 255→0.
- Sequence checker:
  - 2-bit index `exp_idx` selects expected data: 0→3'b111, 1→3'b101, 2→3'b110.
  - On push: if data_up ≠ expected[exp_idx], set `seq_err`. Then advance exp_idx, wrapping 2→0.
  - When `valid_up` is low, exp_idx is cleared to 0. This matches the master, which restarts its sequence when valid drops.
  - With `valid_up` high and no push, exp_idx holds.
  - `seq_err` clears only on reset.
- Data presented while `ready_up` is low is ignored: no push, no check, no count.

## Timing
- Reset values: phase 0, count 0, pointers 0, exp_idx 0, beat_cnt 0, seq_err 0, valid_dn 0, data_dn 0, ready_up = READY_PATTERN[0].
- Reset asserted mid-operation: all state returns to reset values asynchronously, and buffered beats are discarded.
- Latency: a beat pushed at edge k appears on `valid_dn`/`data_dn` after edge k, provided the FIFO was empty.
- Throughput: one push and one pop per cycle sustained when READY_PATTERN = 4'b1111 and `ready_dn` is high.
- `seq_err` and `beat_cnt` update at the same edge as the offending or counted push.
- `ready_up` low for exactly one cycle after the FIFO becomes full, if a pop occurs in that cycle.

## Structure
- Package `bus_pkg`:
  - DATA_W = 3.
  - Expected-sequence constants SEQ0/SEQ1/SEQ2 = 3'b111/3'b101/3'b110, shared with `master`.
  - SEQ_LEN = 3.
- Sub-module `sync_fifo` (parameters DEPTH and DATA_W; ports push/pop/full/empty/dout).
- Throttle logic, checker and counter live in `slave`.

## Test plan
- Reset with READY_PATTERN 4'b1111; master sends 111,101,110 with ready_dn=1 → valid_dn pulses one cycle later carrying 111,101,110; beat_cnt=3; seq_err=0.
- ready_dn=0, valid_up held high, DEPTH=4 → four pushes, ready_up drops after the 4th, beat_cnt=4. Then assert ready_dn → data drains in order and ready_up rises one cycle after the first pop.
- READY_PATTERN=4'b0101, valid_up held high → pushes only in phases 0 and 2. Data order on data_dn is still 111,101,110; seq_err=0.
- Inject data_up=3'b000 as the 2nd accepted beat → seq_err=1 at that edge and stays 1 through subsequent correct beats.
- Drop valid_up for one cycle after two beats, then resend 111 → no error, because exp_idx was cleared to 0.
- Assert sys_rst while the FIFO holds 3 beats → valid_dn, beat_cnt and seq_err go to 0 immediately. After release, ready_up = READY_PATTERN[0].
